// File: rtl/karatsuba_pkg.sv
// Shared widths and the stage-1 operand record for the Karatsuba MAC arbiter.
package karatsuba_pkg;

  localparam int unsigned OPW      = 16;
  localparam int unsigned PRODW    = 32;
  localparam int unsigned ACCW_DEF = 40;

  // Operand payload captured in stage 1; the owning requester id rides alongside.
  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           acc;
  } s1_op_t;

endpackage

// File: rtl/karatsuba_mac_4digit.sv
// Unsigned 16x16 Karatsuba multiplier: two 8-bit digits per operand, three sub-products.
import karatsuba_pkg::*;

module karatsuba_mac_4digit (
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [PRODW-1:0] product
);

  logic [15:0] z2;
  logic [15:0] z0;
  logic [8:0]  sa;
  logic [8:0]  sb;
  logic [17:0] z1;
  logic [17:0] mid;

  always_comb begin
    z2  = {8'b0, a[15:8]} * {8'b0, b[15:8]};
    z0  = {8'b0, a[7:0]} * {8'b0, b[7:0]};
    sa  = {1'b0, a[15:8]} + {1'b0, a[7:0]};
    sb  = {1'b0, b[15:8]} + {1'b0, b[7:0]};
    z1  = {9'b0, sa} * {9'b0, sb};
    // Cross term is always non-negative, so 18 bits cannot underflow.
    mid = z1 - {2'b0, z2} - {2'b0, z0};
    product = {z2, z0} + {6'b0, mid, 8'b0};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDW-1:0]     id_c,
  output logic               any_c
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant_c = '0;
    id_c    = '0;
    any_c   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // NUM_REQ is a power of two, so the IDW-bit add wraps naturally.
      idx = rr_ptr + IDW'(k);
      if (!any_c && req[idx]) begin
        any_c        = 1'b1;
        grant_c[idx] = 1'b1;
        id_c         = idx;
      end
    end
  end

endmodule

// File: rtl/karatsuba_mac_arbiter.sv
// NUM_REQ virtual MAC units sharing one Karatsuba multiplier: operand stage, then
// multiply-accumulate/response stage, with per-requester accumulators.
import karatsuba_pkg::*;

module karatsuba_mac_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned ACCW    = ACCW_DEF,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*OPW-1:0] req_a,
  input  logic [NUM_REQ*OPW-1:0] req_b,
  input  logic [NUM_REQ-1:0]     req_acc,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [ACCW-1:0]        rsp_data,
  output logic                   busy
);

  logic [NUM_REQ-1:0] grant_c;
  logic [IDW-1:0]     gid_c;
  logic               any_c;
  logic               adv_c;
  logic [IDW-1:0]     rr_ptr;
  s1_op_t             s1_op;
  s1_op_t             s1_nxt_c;
  logic [IDW-1:0]     s1_id;
  logic               s1_valid;
  logic [PRODW-1:0]   product_c;
  logic [ACCW-1:0]    sum_c;
  logic [ACCW-1:0]    acc_q [NUM_REQ];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .grant_c (grant_c),
    .id_c    (gid_c),
    .any_c   (any_c)
  );

  karatsuba_mac_4digit u_mul (
    .a       (s1_op.a),
    .b       (s1_op.b),
    .product (product_c)
  );

  // A full response register with no taker stalls the whole pipeline.
  assign adv_c     = !rsp_valid || rsp_ready;
  assign req_ready = adv_c ? grant_c : '0;
  assign busy      = s1_valid || rsp_valid;

  // Operand mux for the granted requester.
  always_comb begin
    s1_nxt_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        s1_nxt_c.a   = req_a[i*OPW +: OPW];
        s1_nxt_c.b   = req_b[i*OPW +: OPW];
        s1_nxt_c.acc = req_acc[i];
      end
    end
  end

  assign sum_c = (s1_op.acc ? acc_q[s1_id] : '0) + ACCW'(product_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      s1_op     <= '0;
      s1_id     <= '0;
      s1_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) acc_q[i] <= '0;
    end else if (adv_c) begin
      s1_op    <= s1_nxt_c;
      s1_id    <= gid_c;
      s1_valid <= any_c;
      if (any_c) rr_ptr <= IDW'(gid_c + IDW'(1));
      // Accumulator update lands on the same edge a younger op from the same
      // requester enters stage 2, so no bypass is needed.
      if (s1_valid) begin
        acc_q[s1_id] <= sum_c;
        rsp_data     <= sum_c;
        rsp_id       <= s1_id;
        rsp_valid    <= 1'b1;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/karatsuba_mac_arbiter.md
Name: karatsuba_mac_arbiter

Overview:
Shares one 16x16 karatsuba_mac_4digit multiplier between NUM_REQ requesters. Arbitration is round-robin. Each requester has its own wide accumulator, so the block works as NUM_REQ virtual MAC units time-multiplexed on one multiplier. It is a two-stage pipeline (operand register, then multiply-accumulate/response register) with valid/ready handshakes on both sides. It sits between the LDMM compute front-end and the Karatsuba datapath.

Parameters:
NUM_REQ, 4, number of requesters; power of two, >= 2
OPW, 16, operand width; fixed by the multiplier
ACCW, 40, per-requester accumulator and response width; >= 2*OPW
IDW, $clog2(NUM_REQ), requester id width (derived localparam)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  NUM_REQ*OPW  operand A, requester i at [i*OPW +: OPW]
req_b  in  NUM_REQ*OPW  operand B, same packing
req_acc  in  NUM_REQ  1 = add product to accumulator; 0 = load product (start new sum)
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  requester that owns the response
rsp_data  out  ACCW  updated accumulator value
busy  out  1  s1_valid | rsp_valid

Behaviour:
- Reset (async, rst_n=0): rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0, busy=0. s1_valid=0, rr_ptr=0, all accumulators=0. Reset mid-operation drops all in-flight operations silently.
- advance = !rsp_valid | rsp_ready. This is a combinational stall for the whole pipeline.
- Arbitration (combinational): starting at rr_ptr, grant the first i with req_valid[i]=1, searching upward with wrap at NUM_REQ-1.
- req_ready[i] = advance & grant[i]. A transfer occurs when req_valid[i] & req_ready[i] are both high.
- rr_ptr <= granted id + 1 (mod NUM_REQ), only on a transfer. rr_ptr holds when idle or stalled.
- Stage 1, on advance: s1 register takes {a, b, id, acc_flag} of the granted requester. s1_valid <= any transfer.
- Stage 2: the multiplier is driven combinationally from s1_a/s1_b. product is a 32-bit unsigned value equal to s1_a*s1_b for every 16-bit operand pair.
- On advance & s1_valid:
  - sum = (s1_acc ? acc[s1_id] : 0) + zero-extended product, computed mod 2^ACCW (wraps silently, no saturation).
  - acc[s1_id] <= sum; rsp_data <= sum; rsp_id <= s1_id; rsp_valid <= 1.
- On advance & !s1_valid: rsp_valid <= 0.
- Latency: a request accepted at edge N gives rsp_valid=1 after edge N+1 (2 cycles). Throughput is one op per cycle when rsp_ready=1.
- Back-to-back ops from the same requester need no bypass. The accumulator is written on the same edge the older op leaves stage 2, before the younger op reads it.
- Stall (rsp_valid & !rsp_ready):
  - rsp_*, s1, accumulators and rr_ptr hold.
  - req_ready = 0.
  - Requesters must hold valid and operands.
- Requester i deasserting req_valid without a transfer is legal; no state changes.
- req_acc=0 on the first op after reset is not required, because accumulators reset to 0.

Decomposition:
- Package karatsuba_pkg: OPW, PRODW=32, default ACCW, and a struct/typedef for the stage-1 record {a, b, id, acc}.
- Sub-module rr_arbiter (NUM_REQ): req vector and rr_ptr in, one-hot grant and encoded id out, purely combinational.
- The existing karatsuba_mac_4digit is instantiated unchanged as the multiplier.

Test Plan:
- Single op: req0 a=1234 b=4321 acc=0 -> 2 cycles later rsp_id=0, rsp_data=5332114.
- Accumulate: req1 a=1111 b=2222 acc=0, then acc=1 on the next cycle -> responses 2468642, then 4937284; a third op with acc=0 -> 2468642.
- Round-robin: all four req_valid held high with distinct operands -> grant order 0,1,2,3,0,1; rsp_id follows the same order at one op per cycle.
- Backpressure: hold rsp_ready=0 for 3 cycles while responses are pending -> rsp_valid/rsp_data/rsp_id stable, req_ready=0, no op lost or duplicated afterwards.
- Wrap: req2 a=b=65535, one acc=0 op then 256 acc=1 ops (257 total) -> final rsp_data=4261282049; after 256 total ops (acc=0 plus 255 acc=1) rsp_data=1099478073600.
- Reset mid-op: assert rst_n=0 with s1 and response both valid -> outputs 0 immediately. After release, req3 a=2 b=3 acc=1 -> rsp_data=6, and the grant search starts at requester 0.
